// File: rtl/uart_rx_pkt_buf.sv
// Packet buffer behind uart_rx: bytes go into a FIFO and the final byte of each packet is tagged.
// The newest byte is held back until the next byte or eop decides whether it is the last one.
module uart_rx_pkt_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_eop,
    output logic          m_valid,
    output logic [7:0]    m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic [AW:0]   level,
    output logic [AW:0]   pkt_cnt,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [7:0]    mem_data [DEPTH];
    logic          mem_last [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   pkt_cnt_q, pkt_cnt_d;
    logic          pend_q, pend_d;
    logic          ovf_q, ovf_d;

    logic          full;
    logic          wr_en;
    logic          eop_en;
    logic          pop;
    logic          pop_last;
    logic [AW:0]   committed;
    logic [AW-1:0] pend_ptr;

    always_comb begin
        full      = (count_q == FullCount);
        wr_en     = rx_ready & ~full;
        eop_en    = rx_eop & pend_q;
        committed = count_q - (AW+1)'(pend_q);
        pop       = (committed != '0) & m_ready;
        pop_last  = pop & mem_last[rd_ptr_q];
        // The pending entry is always the most recently written one.
        pend_ptr  = wr_ptr_q - AW'(1);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        pkt_cnt_d = pkt_cnt_q + (AW+1)'(eop_en) - (AW+1)'(pop_last);
        // An eop in the same cycle as a write closes the old pending byte; the new one takes its place.
        pend_d    = wr_en ? 1'b1 : (eop_en ? 1'b0 : pend_q);
        ovf_d     = (ovf_q & ~ovf_clr) | (rx_ready & full);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pkt_cnt_q <= '0;
            pend_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pkt_cnt_q <= pkt_cnt_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is not reset; entries are only ever read once committed.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_data[wr_ptr_q] <= rx_data;
            mem_last[wr_ptr_q] <= 1'b0;
        end
        if (eop_en) begin
            mem_last[pend_ptr] <= 1'b1;
        end
    end

    always_comb begin
        m_valid = (committed != '0);
        m_data  = mem_data[rd_ptr_q];
        m_last  = mem_last[rd_ptr_q];
        level   = count_q;
        pkt_cnt = pkt_cnt_q;
        ovf     = ovf_q;
    end

endmodule

// File: tb/tb_uart_rx_pkt_buf.sv
// Directed bench for uart_rx_pkt_buf: packet tagging, eop corner cases, overflow, wrap and reset.
`timescale 1ns/1ps
module tb_uart_rx_pkt_buf;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_eop = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready = 1'b0;
    logic [4:0] level;
    logic [4:0] pkt_cnt;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int nvec = 0;
    int nerr = 0;

    logic       mon_en = 1'b0;
    logic [7:0] cap_data [$];
    logic       cap_last [$];
    int         pkt_max = 0;

    uart_rx_pkt_buf #(.DEPTH(16)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .rx_ready(rx_ready),
        .rx_data (rx_data),
        .rx_eop  (rx_eop),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_ready (m_ready),
        .level   (level),
        .pkt_cnt (pkt_cnt),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #42 CLK = ~CLK;

    // Records every byte the consumer takes, sampled mid-cycle before the popping edge.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (m_valid && m_ready) begin
                cap_data.push_back(m_data);
                cap_last.push_back(m_last);
            end
            if (int'(pkt_cnt) > pkt_max) pkt_max = int'(pkt_cnt);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic send_eop();
        rx_eop = 1'b1;
        tick();
        rx_eop = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        #5;
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        nvec++; if (level !== 5'd0) begin nerr++; $display("FAIL reset_level got %0d want 0", level); end
        nvec++; if (pkt_cnt !== 5'd0) begin nerr++; $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); end
        nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        tick();
        @(negedge CLK);
        RSTn = 1'b1;
        tick();
    endtask

    task automatic test_hello();
        send_byte(8'h48);
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL hello_pending_hidden got %0b want 0", m_valid); end
        nvec++; if (level !== 5'd1) begin nerr++; $display("FAIL hello_level1 got %0d want 1", level); end
        send_byte(8'h65);
        nvec++; if (m_valid !== 1'b1) begin nerr++; $display("FAIL hello_valid got %0b want 1", m_valid); end
        nvec++; if (level !== 5'd2) begin nerr++; $display("FAIL hello_level2 got %0d want 2", level); end
        nvec++; if (m_data !== 8'h48) begin nerr++; $display("FAIL hello_data0 got %h want 48", m_data); end
        nvec++; if (m_last !== 1'b0) begin nerr++; $display("FAIL hello_last0 got %0b want 0", m_last); end
        send_eop();
        nvec++; if (pkt_cnt !== 5'd1) begin nerr++; $display("FAIL hello_pkt_cnt got %0d want 1", pkt_cnt); end
        m_ready = 1'b1;
        tick();
        nvec++; if (m_data !== 8'h65) begin nerr++; $display("FAIL hello_data1 got %h want 65", m_data); end
        nvec++; if (m_last !== 1'b1) begin nerr++; $display("FAIL hello_last1 got %0b want 1", m_last); end
        nvec++; if (pkt_cnt !== 5'd1) begin nerr++; $display("FAIL hello_pkt_hold got %0d want 1", pkt_cnt); end
        tick();
        m_ready = 1'b0;
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL hello_drained got %0b want 0", m_valid); end
        nvec++; if (pkt_cnt !== 5'd0) begin nerr++; $display("FAIL hello_pkt_zero got %0d want 0", pkt_cnt); end
        nvec++; if (level !== 5'd0) begin nerr++; $display("FAIL hello_level0 got %0d want 0", level); end
    endtask

    task automatic test_eop_ignored();
        send_eop();
        nvec++; if (pkt_cnt !== 5'd0) begin nerr++; $display("FAIL empty_eop_pkt got %0d want 0", pkt_cnt); end
        nvec++; if (level !== 5'd0) begin nerr++; $display("FAIL empty_eop_level got %0d want 0", level); end
        send_byte(8'h11);
        send_byte(8'h22);
        send_eop();
        send_eop();
        nvec++; if (pkt_cnt !== 5'd1) begin nerr++; $display("FAIL repeat_eop_pkt got %0d want 1", pkt_cnt); end
        nvec++; if (level !== 5'd2) begin nerr++; $display("FAIL repeat_eop_level got %0d want 2", level); end
        nvec++; if (m_data !== 8'h11) begin nerr++; $display("FAIL repeat_eop_data0 got %h want 11", m_data); end
        nvec++; if (m_last !== 1'b0) begin nerr++; $display("FAIL repeat_eop_last0 got %0b want 0", m_last); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        nvec++; if (m_data !== 8'h22) begin nerr++; $display("FAIL repeat_eop_data1 got %h want 22", m_data); end
        nvec++; if (m_last !== 1'b1) begin nerr++; $display("FAIL repeat_eop_last1 got %0b want 1", m_last); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        nvec++; if (pkt_cnt !== 5'd0) begin nerr++; $display("FAIL repeat_eop_pkt_end got %0d want 0", pkt_cnt); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 17; k++) send_byte(8'(k));
        nvec++; if (level !== 5'd16) begin nerr++; $display("FAIL ovf_level got %0d want 16", level); end
        nvec++; if (ovf !== 1'b1) begin nerr++; $display("FAIL ovf_set got %0b want 1", ovf); end
        send_eop();
        nvec++; if (pkt_cnt !== 5'd1) begin nerr++; $display("FAIL ovf_eop_pkt got %0d want 1", pkt_cnt); end
        // Clear and drop in the same cycle: the set wins.
        ovf_clr = 1'b1;
        send_byte(8'hEE);
        ovf_clr = 1'b0;
        nvec++; if (ovf !== 1'b1) begin nerr++; $display("FAIL ovf_set_wins got %0b want 1", ovf); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL ovf_clr got %0b want 0", ovf); end
        nvec++; if (level !== 5'd16) begin nerr++; $display("FAIL ovf_level_hold got %0d want 16", level); end
        m_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            nvec++;
            if (m_valid !== 1'b1 || m_data !== 8'(k) || m_last !== (k == 16)) begin
                nerr++;
                $display("FAIL ovf_pop%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                         k, m_valid, m_data, m_last, 8'(k), (k == 16));
            end
            tick();
        end
        m_ready = 1'b0;
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL ovf_drained got %0b want 0", m_valid); end
        nvec++; if (pkt_cnt !== 5'd0) begin nerr++; $display("FAIL ovf_pkt_end got %0d want 0", pkt_cnt); end
        nvec++; if (level !== 5'd0) begin nerr++; $display("FAIL ovf_level_end got %0d want 0", level); end
    endtask

    task automatic test_stream();
        cap_data.delete();
        cap_last.delete();
        pkt_max = 0;
        m_ready = 1'b1;
        mon_en  = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(p * 7 + i));
            send_eop();
        end
        repeat (3) tick();
        mon_en  = 1'b0;
        m_ready = 1'b0;
        nvec++; if (cap_data.size() != 21) begin nerr++; $display("FAIL stream_count got %0d want 21", cap_data.size()); end
        for (int n = 0; n < 21; n++) begin
            if (n < cap_data.size()) begin
                nvec++;
                if (cap_data[n] !== 8'h30 + 8'(n) || cap_last[n] !== ((n % 7) == 6)) begin
                    nerr++;
                    $display("FAIL stream_byte%0d got d=%h l=%0b want d=%h l=%0b",
                             n, cap_data[n], cap_last[n], 8'h30 + 8'(n), ((n % 7) == 6));
                end
            end
        end
        nvec++; if (pkt_max > 1) begin nerr++; $display("FAIL stream_pkt_max got %0d want <=1", pkt_max); end
        nvec++; if (level !== 5'd0) begin nerr++; $display("FAIL stream_level_end got %0d want 0", level); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        nvec++; if (level !== 5'd3) begin nerr++; $display("FAIL mid_level got %0d want 3", level); end
        #10;
        RSTn = 1'b0;
        #1;
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_valid got %0b want 0", m_valid); end
        nvec++; if (level !== 5'd0) begin nerr++; $display("FAIL mid_rst_level got %0d want 0", level); end
        nvec++; if (pkt_cnt !== 5'd0) begin nerr++; $display("FAIL mid_rst_pkt got %0d want 0", pkt_cnt); end
        @(negedge CLK);
        RSTn = 1'b1;
        tick();
        send_byte(8'hAA);
        send_eop();
        nvec++; if (m_valid !== 1'b1) begin nerr++; $display("FAIL mid_aa_valid got %0b want 1", m_valid); end
        nvec++; if (m_data !== 8'hAA) begin nerr++; $display("FAIL mid_aa_data got %h want aa", m_data); end
        nvec++; if (m_last !== 1'b1) begin nerr++; $display("FAIL mid_aa_last got %0b want 1", m_last); end
        nvec++; if (level !== 5'd1) begin nerr++; $display("FAIL mid_aa_level got %0d want 1", level); end
        nvec++; if (pkt_cnt !== 5'd1) begin nerr++; $display("FAIL mid_aa_pkt got %0d want 1", pkt_cnt); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL mid_aa_drained got %0b want 0", m_valid); end
        nvec++; if (pkt_cnt !== 5'd0) begin nerr++; $display("FAIL mid_aa_pkt_end got %0d want 0", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_eop_ignored();
        test_overflow();
        test_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
